// File: rtl/card_match_engine_pkg.sv
// Shared card-game definitions: board geometry, FSM encodings and the symbol
// lookup used by both the shuffler and the match engine.
package card_match_engine_pkg;

  localparam int NUM_CARDS = 16;
  localparam int SYM_W     = 3;
  localparam int NUM_PAIRS = 8;
  localparam int IDX_W     = 4;
  localparam int MAP_W     = NUM_CARDS * SYM_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PICK1   = 3'd1,
    ST_PICK2   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_SHOW    = 3'd4,
    ST_WIN     = 3'd5
  } card_state_t;

  // Card i occupies map[3i +: 3]; the map is ascending, so map[3i] is the MSB.
  function automatic logic [SYM_W-1:0] card_sym(input logic [0:MAP_W-1] map,
                                                input logic [IDX_W-1:0] idx);
    return map[SYM_W * int'(idx) +: SYM_W];
  endfunction

endpackage

// File: rtl/card_match_engine_delay_timer.sv
// One-shot delay: after start, counts 0..HIDE_CYCLES-1 and flags done on the
// terminal count. clear aborts a pending countdown without firing done.
module delay_timer
  #(
    parameter int HIDE_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
  )
  (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic start,
    output logic done
  );

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HIDE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             run_r;

  // Countdown state; clear has priority so a reload can never leak a done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (clear) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (start) begin
      cnt_r <= '0;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == TERM) begin
        cnt_r <= '0;
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
        run_r <= 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
      run_r <= run_r;
    end
  end

  assign done = run_r && (cnt_r == TERM);

endmodule

// File: rtl/card_match_engine.sv
// Memory-game match engine: accepts two card picks, compares their symbols,
// keeps matches face-up and hides mismatches after a timed display.
module card_match_engine
  import card_match_engine_pkg::*;
  #(
    parameter int HIDE_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
  )
  (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic [0:MAP_W-1]     map_in,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [3:0]           pair_cnt,
    output logic [7:0]           attempts,
    output logic                 result_valid,
    output logic                 result_match,
    output logic                 ready,
    output logic                 win
  );

  card_state_t          state_r, state_nxt_s;
  logic [0:MAP_W-1]     map_r, map_nxt_s;
  logic [IDX_W-1:0]     first_r, first_nxt_s;
  logic [IDX_W-1:0]     second_r, second_nxt_s;
  logic [NUM_CARDS-1:0] face_up_r, face_up_nxt_s;
  logic [NUM_CARDS-1:0] matched_r, matched_nxt_s;
  logic [3:0]           pair_cnt_r, pair_cnt_nxt_s;
  logic [7:0]           attempts_r, attempts_nxt_s;
  logic                 result_valid_r, result_valid_nxt_s;
  logic                 result_match_r, result_match_nxt_s;
  logic                 ready_r, ready_nxt_s;
  logic                 win_r, win_nxt_s;

  logic                 sel_ok_s;
  logic                 sym_eq_s;
  logic [NUM_CARDS-1:0] sel_mask_s;
  logic [NUM_CARDS-1:0] pair_mask_s;
  logic                 timer_start_s;
  logic                 timer_clear_s;
  logic                 timer_done_s;

  // ready_r mirrors PICK1/PICK2, so it doubles as the state qualifier here.
  assign sel_ok_s    = sel_valid && ready_r && (face_up_r[sel_idx] == 1'b0);
  assign sel_mask_s  = 16'h0001 << sel_idx;
  assign pair_mask_s = (16'h0001 << first_r) | (16'h0001 << second_r);
  assign sym_eq_s    = (card_sym(map_r, first_r) == card_sym(map_r, second_r));

  delay_timer #(
    .HIDE_CYCLES (HIDE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hide_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (timer_clear_s),
    .start  (timer_start_s),
    .done   (timer_done_s)
  );

  // Next-state and next-datapath logic; load overrides everything else.
  always_comb begin
    state_nxt_s        = state_r;
    map_nxt_s          = map_r;
    first_nxt_s        = first_r;
    second_nxt_s       = second_r;
    face_up_nxt_s      = face_up_r;
    matched_nxt_s      = matched_r;
    pair_cnt_nxt_s     = pair_cnt_r;
    attempts_nxt_s     = attempts_r;
    result_valid_nxt_s = 1'b0;
    result_match_nxt_s = result_match_r;
    timer_start_s      = 1'b0;
    timer_clear_s      = 1'b0;

    if (load) begin
      state_nxt_s        = ST_PICK1;
      map_nxt_s          = map_in;
      first_nxt_s        = '0;
      second_nxt_s       = '0;
      face_up_nxt_s      = '0;
      matched_nxt_s      = '0;
      pair_cnt_nxt_s     = 4'd0;
      attempts_nxt_s     = 8'd0;
      result_match_nxt_s = 1'b0;
      timer_clear_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_PICK1: begin
          if (sel_ok_s) begin
            face_up_nxt_s = face_up_r | sel_mask_s;
            first_nxt_s   = sel_idx;
            state_nxt_s   = ST_PICK2;
          end else begin
            state_nxt_s = ST_PICK1;
          end
        end
        ST_PICK2: begin
          if (sel_ok_s) begin
            face_up_nxt_s = face_up_r | sel_mask_s;
            second_nxt_s  = sel_idx;
            state_nxt_s   = ST_COMPARE;
          end else begin
            state_nxt_s = ST_PICK2;
          end
        end
        ST_COMPARE: begin
          result_valid_nxt_s = 1'b1;
          result_match_nxt_s = sym_eq_s;
          if (attempts_r != 8'hFF) begin
            attempts_nxt_s = attempts_r + 8'd1;
          end else begin
            attempts_nxt_s = attempts_r;
          end
          if (sym_eq_s) begin
            matched_nxt_s  = matched_r | pair_mask_s;
            pair_cnt_nxt_s = pair_cnt_r + 4'd1;
            if (pair_cnt_r == 4'(NUM_PAIRS - 1)) begin
              state_nxt_s = ST_WIN;
            end else begin
              state_nxt_s = ST_PICK1;
            end
          end else begin
            timer_start_s = 1'b1;
            state_nxt_s   = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer_done_s) begin
            face_up_nxt_s = face_up_r & ~pair_mask_s;
            state_nxt_s   = ST_PICK1;
          end else begin
            state_nxt_s = ST_SHOW;
          end
        end
        ST_WIN: begin
          state_nxt_s = ST_WIN;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    ready_nxt_s = (state_nxt_s == ST_PICK1) || (state_nxt_s == ST_PICK2);
    win_nxt_s   = (state_nxt_s == ST_WIN);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      map_r          <= '0;
      first_r        <= '0;
      second_r       <= '0;
      face_up_r      <= '0;
      matched_r      <= '0;
      pair_cnt_r     <= 4'd0;
      attempts_r     <= 8'd0;
      result_valid_r <= 1'b0;
      result_match_r <= 1'b0;
      ready_r        <= 1'b0;
      win_r          <= 1'b0;
    end else begin
      map_r          <= map_nxt_s;
      first_r        <= first_nxt_s;
      second_r       <= second_nxt_s;
      face_up_r      <= face_up_nxt_s;
      matched_r      <= matched_nxt_s;
      pair_cnt_r     <= pair_cnt_nxt_s;
      attempts_r     <= attempts_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      result_match_r <= result_match_nxt_s;
      ready_r        <= ready_nxt_s;
      win_r          <= win_nxt_s;
    end
  end

  assign face_up      = face_up_r;
  assign matched      = matched_r;
  assign pair_cnt     = pair_cnt_r;
  assign attempts     = attempts_r;
  assign result_valid = result_valid_r;
  assign result_match = result_match_r;
  assign ready        = ready_r;
  assign win          = win_r;

endmodule
